seg_serial_tx: RTL

//  Serialiser downstream of the clock's display encoder: captures the 64-bit seven-segment pattern (disp_num, 8 digits x 8 segs).

---
 rtl/seg_serial_tx_pkg.sv | 5 +
 rtl/seg_div_tick.sv | 16 +
 rtl/seg_serial_tx.sv | 76 +++++++
 3 files changed

// File: rtl/seg_serial_tx_pkg.sv
// seg_serial_tx_pkg: shared FSM states and frame width for the segment serialiser
package seg_serial_tx_pkg;
  localparam int SEG_FRAME_W = 64;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} seg_state_e;
endpackage

// File: rtl/seg_div_tick.sv
// seg_div_tick: phase counter that ticks on the last clk of each CLK_DIV-long phase
module seg_div_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV + 1);
  logic [DW-1:0] div_cnt;
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + DW'(1);
endmodule

// File: rtl/seg_serial_tx.sv
// seg_serial_tx: shifts a seven-segment frame MSB-first onto SEG_CLK/SEG_DT, then pulses SEG_LATCH
module seg_serial_tx
  import seg_serial_tx_pkg::*;
#(
  parameter int DATA_W   = SEG_FRAME_W,
  parameter int CLK_DIV  = 2,
  parameter int AUTO_RUN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] disp_num,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              SEG_CLK,
  output logic              SEG_DT,
  output logic              SEG_LATCH
);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  seg_state_e state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic tick, go, div_clr;
  assign div_clr = state == IDLE || state == DONE;
  assign go = state == IDLE ? start : (state == DONE && AUTO_RUN != 0);
  seg_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .tick (tick)
  );
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    case (state)
      IDLE, DONE: begin
        state_nxt = go ? SHIFT_LO : IDLE;
        if (go) begin
          shreg_nxt   = disp_num;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT_LO: state_nxt = tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (tick) begin
        shreg_nxt   = shreg << 1;
        bit_cnt_nxt = bit_cnt + BW'(1);
        state_nxt   = bit_cnt == LAST ? LATCH : SHIFT_LO;
      end
      LATCH:    state_nxt = tick ? DONE : LATCH;
      default:  state_nxt = IDLE;
    endcase
  end
  // Pins are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SEG_CLK   <= 1'b0;
      SEG_DT    <= 1'b0;
      SEG_LATCH <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      busy      <= state_nxt == SHIFT_LO || state_nxt == SHIFT_HI || state_nxt == LATCH;
      done      <= state_nxt == DONE;
      SEG_CLK   <= state_nxt == SHIFT_HI;
      SEG_DT    <= (state_nxt == SHIFT_LO || state_nxt == SHIFT_HI) ? shreg_nxt[DATA_W-1] : 1'b0;
      SEG_LATCH <= state_nxt == LATCH;
    end
endmodule
